// File: rtl/gpio_acq_sequencer.sv
// Host-side sequencer for the GPIO command/data port: trigger set, start, inquiry
// polling, N single-word reads and stop, with read words returned on a valid/ready stream.
module gpio_acq_sequencer #(
  parameter int HOLD    = 2,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        _RESET_in,
  input  logic        GO_in,
  input  logic        ABORT_in,
  input  logic [15:0] FRAME_in,
  input  logic [13:0] TRGLEVEL_in,
  output logic [31:0] SELECT_out,
  input  logic [31:0] GPIO_in,
  output logic [31:0] DATA_out,
  output logic        DATAvalid_out,
  input  logic        DATAready_in,
  output logic        BUSY_out,
  output logic        DONE_out,
  output logic        TIMEOUT_out,
  output logic [2:0]  STATE_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRGSET  = 3'd1,
    S_START   = 3'd2,
    S_INQUIRY = 3'd3,
    S_READ    = 3'd4,
    S_OUT     = 3'd5,
    S_STOP    = 3'd6
  } state_t;

  localparam int SLOT_LEN = HOLD + GAP;
  localparam int SLOT_W   = $clog2(SLOT_LEN);
  localparam logic [SLOT_W-1:0] HOLD_LAST = SLOT_W'(HOLD - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
  localparam logic [15:0]       TIMEOUT_W = 16'(TIMEOUT);

  state_t              state_r, state_nxt_s;
  logic [SLOT_W-1:0]   slot_r, slot_nxt_s;
  logic [15:0]         frame_r, poll_r, word_r;
  logic [13:0]         trg_r, trg_src_s;
  logic [31:0]         select_r, select_nxt_s, data_r;
  logic                count_ok_r, valid_r, busy_r, done_r, timeout_r;
  logic                go_acc_s, abort_s, slot_end_s, hold_last_s, poll_last_s, word_last_s;

  function automatic logic [31:0] cmd_word(input state_t st, input logic [13:0] trg);
    case (st)
      S_TRGSET:  return {2'b00, trg, 16'h0020};
      S_START:   return 32'h0000_0001;
      S_INQUIRY: return 32'h0000_0002;
      S_READ:    return 32'h0000_0004;
      S_STOP:    return 32'h0000_0008;
      default:   return 32'h0000_0000;
    endcase
  endfunction

  assign go_acc_s    = (state_r == S_IDLE) && GO_in;
  assign abort_s     = ABORT_in && (state_r != S_IDLE) && (state_r != S_STOP);
  assign slot_end_s  = (slot_r == SLOT_LAST);
  assign hold_last_s = (slot_r == HOLD_LAST);
  assign poll_last_s = ((poll_r + 16'd1) == TIMEOUT_W);
  assign word_last_s = ((word_r + 16'd1) == frame_r);
  // TRGSET is entered straight from IDLE, before the level register has been loaded
  assign trg_src_s   = (state_r == S_IDLE) ? TRGLEVEL_in : trg_r;

  // Next-state, slot position and the SELECT word for the coming cycle
  always_comb begin
    state_nxt_s = state_r;
    slot_nxt_s  = slot_end_s ? '0 : slot_r + SLOT_W'(1);
    case (state_r)
      S_IDLE: begin
        slot_nxt_s = '0;
        if (GO_in) state_nxt_s = S_TRGSET;
        else       state_nxt_s = S_IDLE;
      end
      S_TRGSET: begin
        if (slot_end_s) state_nxt_s = S_START;
        else            state_nxt_s = S_TRGSET;
      end
      S_START: begin
        if (slot_end_s) state_nxt_s = (frame_r == 16'd0) ? S_STOP : S_INQUIRY;
        else            state_nxt_s = S_START;
      end
      S_INQUIRY: begin
        if (!slot_end_s)     state_nxt_s = S_INQUIRY;
        else if (count_ok_r) state_nxt_s = S_READ;
        else if (poll_last_s) state_nxt_s = S_STOP;
        else                 state_nxt_s = S_INQUIRY;
      end
      S_READ: begin
        if (slot_end_s) state_nxt_s = S_OUT;
        else            state_nxt_s = S_READ;
      end
      S_OUT: begin
        slot_nxt_s = '0;
        if (DATAready_in) state_nxt_s = word_last_s ? S_STOP : S_READ;
        else              state_nxt_s = S_OUT;
      end
      S_STOP: begin
        if (slot_end_s) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_STOP;
      end
      default: begin
        state_nxt_s = S_IDLE;
        slot_nxt_s  = '0;
      end
    endcase
    if (abort_s) begin
      state_nxt_s = S_STOP;
      slot_nxt_s  = '0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
    select_nxt_s = (slot_nxt_s <= HOLD_LAST) ? cmd_word(state_nxt_s, trg_src_s) : 32'h0000_0000;
  end

  // State, frame bookkeeping and all registered outputs
  always_ff @(posedge clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      state_r    <= S_IDLE;
      slot_r     <= '0;
      frame_r    <= 16'd0;
      trg_r      <= 14'd0;
      poll_r     <= 16'd0;
      word_r     <= 16'd0;
      count_ok_r <= 1'b0;
      select_r   <= 32'h0000_0000;
      data_r     <= 32'h0000_0000;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      slot_r   <= slot_nxt_s;
      select_r <= select_nxt_s;
      busy_r   <= (state_nxt_s != S_IDLE);
      done_r   <= (state_r == S_STOP) && (state_nxt_s == S_IDLE);
      if (go_acc_s) begin
        frame_r   <= FRAME_in;
        trg_r     <= TRGLEVEL_in;
        timeout_r <= 1'b0;
        poll_r    <= 16'd0;
        word_r    <= 16'd0;
      end
      if ((state_r == S_INQUIRY) && hold_last_s) begin
        count_ok_r <= (GPIO_in[15:0] >= frame_r);
      end
      if ((state_r == S_INQUIRY) && slot_end_s && !abort_s && !count_ok_r) begin
        poll_r <= poll_r + 16'd1;
        if (poll_last_s) timeout_r <= 1'b1;
      end
      if ((state_r == S_READ) && slot_end_s && !abort_s) begin
        data_r  <= GPIO_in;
        valid_r <= 1'b1;
      end else if (state_r == S_OUT) begin
        // an abort drops the pending word even if the consumer accepts it this cycle
        if (abort_s) begin
          valid_r <= 1'b0;
        end else if (DATAready_in) begin
          valid_r <= 1'b0;
          word_r  <= word_r + 16'd1;
        end
      end
    end
  end

  assign SELECT_out    = select_r;
  assign DATA_out      = data_r;
  assign DATAvalid_out = valid_r;
  assign BUSY_out      = busy_r;
  assign DONE_out      = done_r;
  assign TIMEOUT_out   = timeout_r;
  assign STATE_out     = state_r;

endmodule

// File: tb/tb_gpio_acq_sequencer.sv
// Scoreboard bench for gpio_acq_sequencer: a GPIO controller model answers commands,
// a monitor checks the data stream, and each frame is compared to a rule-based model.
module tb_gpio_acq_sequencer;

  localparam int HOLD = 2;
  localparam int GAP = 2;
  localparam int TB_TIMEOUT = 6;
  localparam logic [31:0] C_START = 32'h0000_0001;
  localparam logic [31:0] C_INQ   = 32'h0000_0002;
  localparam logic [31:0] C_READ  = 32'h0000_0004;
  localparam logic [31:0] C_STOP  = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        _RESET_in, GO_in, ABORT_in, DATAready_in;
  logic [15:0] FRAME_in;
  logic [13:0] TRGLEVEL_in;
  logic [31:0] SELECT_out, GPIO_in, DATA_out;
  logic        DATAvalid_out, BUSY_out, DONE_out, TIMEOUT_out;
  logic [2:0]  STATE_out;

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cmd_log[$];
  int run_log[$];
  int gap_viol = 0, zero_polls = 0, poll_idx = 0, reads_issued = 0;
  logic [15:0] cnt_val = 16'd0;
  int delivered = 0, done_cnt = 0, valid_pulses = 0;

  gpio_acq_sequencer #(.HOLD(HOLD), .GAP(GAP), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), ._RESET_in(_RESET_in), .GO_in(GO_in), .ABORT_in(ABORT_in),
    .FRAME_in(FRAME_in), .TRGLEVEL_in(TRGLEVEL_in), .SELECT_out(SELECT_out),
    .GPIO_in(GPIO_in), .DATA_out(DATA_out), .DATAvalid_out(DATAvalid_out),
    .DATAready_in(DATAready_in), .BUSY_out(BUSY_out), .DONE_out(DONE_out),
    .TIMEOUT_out(TIMEOUT_out), .STATE_out(STATE_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // GPIO controller model: answers each new command word, logs slot shapes
  initial begin : gpio_model
    logic [31:0] prev_sel;
    int run, zrun;
    prev_sel = 32'h0; run = 0; zrun = 0;
    GPIO_in = 32'h0;
    forever begin
      @(negedge clk);
      if (prev_sel != 32'h0 && SELECT_out != prev_sel) run_log.push_back(run);
      if (SELECT_out != 32'h0 && SELECT_out != prev_sel) begin
        if (prev_sel == 32'h0 && cmd_log.size() > 0 && zrun < GAP) gap_viol++;
        cmd_log.push_back(SELECT_out);
        run = 0;
        if (SELECT_out == C_INQ) begin
          GPIO_in = {16'($urandom), (poll_idx < zero_polls) ? 16'h0000 : cnt_val};
          poll_idx++;
        end else if (SELECT_out == C_READ) begin
          GPIO_in = $urandom;
          exp_q.push_back(GPIO_in);
          reads_issued++;
        end else begin
          GPIO_in = $urandom;
        end
      end
      if (SELECT_out != 32'h0) run++;
      zrun = (SELECT_out == 32'h0) ? zrun + 1 : 0;
      prev_sel = SELECT_out;
    end
  end

  // Stream monitor: pops the scoreboard on every handshake, checks stability and DONE
  initial begin : monitor
    logic pv, phs;
    logic [31:0] pd;
    pv = 1'b0; phs = 1'b0; pd = 32'h0;
    forever begin
      @(negedge clk);
      if (DATAvalid_out && pv && !phs) chk("data_stable", DATA_out, pd);
      if (DATAvalid_out && !pv) valid_pulses++;
      if (DATAvalid_out && SELECT_out != 32'h0) chk("no_cmd_while_pending", SELECT_out, 32'h0);
      phs = DATAvalid_out && DATAready_in && !ABORT_in;
      if (phs) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got %h required no word", DATA_out);
        end else begin
          chk("data_word", DATA_out, exp_q.pop_front());
          delivered++;
        end
      end
      if (DONE_out) begin
        done_cnt++;
        chk("done_in_idle", {29'h0, STATE_out}, 32'h0);
        chk("done_not_busy", {31'h0, BUSY_out}, 32'h0);
      end
      pv = DATAvalid_out;
      pd = DATA_out;
    end
  end

  task automatic clear_logs(input int zp, input logic [15:0] cv);
    cmd_log.delete(); run_log.delete(); exp_q.delete();
    gap_viol = 0; zero_polls = zp; cnt_val = cv; poll_idx = 0; reads_issued = 0;
  endtask

  task automatic start_frame(input logic [15:0] frame, input logic [13:0] trg, input bit go_abort,
                             input logic rdy);
    @(posedge clk); #1;
    FRAME_in = frame; TRGLEVEL_in = trg; GO_in = 1'b1; ABORT_in = go_abort; DATAready_in = rdy;
    @(posedge clk); #1;
    GO_in = 1'b0; ABORT_in = 1'b0; FRAME_in = 16'($urandom); TRGLEVEL_in = 14'($urandom);
    chk("go_busy", {31'h0, BUSY_out}, 32'h1);
    chk("go_timeout_clr", {31'h0, TIMEOUT_out}, 32'h0);
  endtask

  // One frame against the reference rules; rmode 0 ready=1, 1 random, 2 ten-cycle stalls
  task automatic run_frame(input string tag, input logic [15:0] frame, input logic [13:0] trg,
                           input int zp, input logic [15:0] cv, input int rmode, input bit go_abort);
    int polls, nreads, d0, done0, v0, budget, stall;
    bit ok, to;
    logic [31:0] exp_cmds[$];
    logic [15:0] c;
    polls = 0; ok = 1'b0;
    if (frame != 16'd0) begin
      while (!ok && polls < TB_TIMEOUT) begin
        c = (polls < zp) ? 16'h0000 : cv;
        polls++;
        if (c >= frame) ok = 1'b1;
      end
    end
    to = (frame != 16'd0) && !ok;
    nreads = ok ? int'(frame) : 0;
    exp_cmds.push_back({2'b00, trg, 16'h0020});
    exp_cmds.push_back(C_START);
    for (int i = 0; i < polls; i++) exp_cmds.push_back(C_INQ);
    for (int i = 0; i < nreads; i++) exp_cmds.push_back(C_READ);
    exp_cmds.push_back(C_STOP);

    clear_logs(zp, cv);
    d0 = delivered; done0 = done_cnt; v0 = valid_pulses;
    start_frame(frame, trg, go_abort, (rmode == 0));
    budget = 0; stall = 0;
    while (done_cnt == done0 && budget < 4000) begin
      case (rmode)
        0: DATAready_in = 1'b1;
        1: DATAready_in = 1'($urandom_range(0, 1));
        default: begin
          if (DATAvalid_out) stall++;
          else stall = 0;
          DATAready_in = (stall > 10);
        end
      endcase
      @(posedge clk); #1;
      budget++;
    end
    chk({tag, "_finished"}, {31'h0, done_cnt != done0}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt - done0, 32'd1);
    chk({tag, "_ncmds"}, cmd_log.size(), exp_cmds.size());
    for (int i = 0; i < exp_cmds.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), (i < cmd_log.size()) ? cmd_log[i] : 32'hdead_beef, exp_cmds[i]);
    for (int i = 0; i < run_log.size(); i++) chk($sformatf("%s_hold%0d", tag, i), run_log[i], HOLD);
    chk({tag, "_gap"}, gap_viol, 32'd0);
    chk({tag, "_delivered"}, delivered - d0, nreads);
    chk({tag, "_valid_pulses"}, valid_pulses - v0, nreads);
    chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    chk({tag, "_timeout"}, {31'h0, TIMEOUT_out}, {31'h0, to});
    chk({tag, "_idle"}, {29'h0, STATE_out}, 32'h0);
    chk({tag, "_not_busy"}, {31'h0, BUSY_out}, 32'h0);
  endtask

  task automatic abort_frame();
    int d0, done0, b;
    clear_logs(0, 16'd9);
    d0 = delivered; done0 = done_cnt;
    start_frame(16'd4, 14'h0abc, 1'b0, 1'b1);
    b = 0;
    while (reads_issued < 2 && b < 500) begin @(posedge clk); b++; end
    #1; ABORT_in = 1'b1; GO_in = 1'b1;
    @(posedge clk); #1; ABORT_in = 1'b0; GO_in = 1'b0;
    @(negedge clk);
    chk("abort_select_stop", SELECT_out, C_STOP);
    chk("abort_valid_low", {31'h0, DATAvalid_out}, 32'h0);
    chk("abort_state_stop", {29'h0, STATE_out}, 32'd6);
    b = 0;
    while (done_cnt == done0 && b < 500) begin @(posedge clk); b++; end
    chk("abort_finished", {31'h0, done_cnt != done0}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_done_once", done_cnt - done0, 32'd1);
    chk("abort_idle", {29'h0, STATE_out}, 32'h0);
    chk("abort_go_ignored", {31'h0, BUSY_out}, 32'h0);
    chk("abort_delivered", delivered - d0, 32'd1);
    chk("abort_ncmds", cmd_log.size(), 32'd6);
    chk("abort_last_cmd", (cmd_log.size() > 0) ? cmd_log[cmd_log.size() - 1] : 32'h0, C_STOP);
    chk("abort_read2", (cmd_log.size() > 4) ? cmd_log[4] : 32'h0, C_READ);
    exp_q.delete();
  endtask

  // Async reset mid-frame: with pending=1 a word is waiting, else a READ word is on SELECT
  task automatic reset_frame(input string tag, input bit pending);
    int done0, b;
    clear_logs(0, 16'd7);
    start_frame(16'd3, 14'h1234, 1'b0, !pending);
    b = 0;
    while (b < 500 && !(pending ? DATAvalid_out : (SELECT_out == C_READ))) begin
      @(posedge clk); #1; b++;
    end
    chk({tag, "_reached"}, {31'h0, b < 500}, 32'h1);
    done0 = done_cnt;
    _RESET_in = 1'b0;
    #2;
    chk({tag, "_select"}, SELECT_out, 32'h0);
    chk({tag, "_valid"}, {31'h0, DATAvalid_out}, 32'h0);
    chk({tag, "_data"}, DATA_out, 32'h0);
    chk({tag, "_state"}, {29'h0, STATE_out}, 32'h0);
    chk({tag, "_busy"}, {31'h0, BUSY_out}, 32'h0);
    repeat (2) @(posedge clk);
    #1; _RESET_in = 1'b1; DATAready_in = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk({tag, "_no_done"}, done_cnt - done0, 32'd0);
    chk({tag, "_stays_idle"}, {29'h0, STATE_out}, 32'h0);
    exp_q.delete();
  endtask

  initial begin : stimulus
    logic [15:0] f;
    _RESET_in = 1'b0; GO_in = 1'b0; ABORT_in = 1'b0; DATAready_in = 1'b0;
    FRAME_in = 16'd0; TRGLEVEL_in = 14'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_select", SELECT_out, 32'h0);
    chk("rst_data", DATA_out, 32'h0);
    chk("rst_flags", {28'h0, DATAvalid_out, BUSY_out, DONE_out, TIMEOUT_out}, 32'h0);
    chk("rst_state", {29'h0, STATE_out}, 32'h0);
    _RESET_in = 1'b1;
    repeat (2) @(posedge clk);

    run_frame("normal", 16'd3, 14'h1234, 0, 16'd5, 0, 1'b0);
    run_frame("bp", 16'd2, 14'h0777, 0, 16'd2, 2, 1'b0);
    run_frame("inq", 16'd8, 14'h2222, 4, 16'd8, 0, 1'b0);
    run_frame("tmo", 16'd3, 14'h3fff, 1000, 16'd0, 1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("tmo_sticky", {31'h0, TIMEOUT_out}, 32'h1);
    run_frame("f0", 16'd0, 14'h1234, 0, 16'd5, 0, 1'b0);
    run_frame("goab", 16'd2, 14'h0101, 1, 16'd4, 1, 1'b1);
    abort_frame();

    @(posedge clk); #1; ABORT_in = 1'b1;
    repeat (3) @(posedge clk);
    #1; ABORT_in = 1'b0;
    chk("idle_abort_busy", {31'h0, BUSY_out}, 32'h0);
    chk("idle_abort_state", {29'h0, STATE_out}, 32'h0);

    reset_frame("rst_read", 1'b0);
    reset_frame("rst_pend", 1'b1);

    for (int i = 0; i < 8; i++) begin
      f = 16'($urandom_range(0, 5));
      run_frame($sformatf("rnd%0d", i), f, 14'($urandom),
                ($urandom_range(0, 4) == 0) ? 1000 : int'($urandom_range(0, 3)),
                16'($urandom_range(0, 8)), 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
